// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: scalar RAM accesses plus a 4-word vector load/store sequencer.
// Optional macro ALIGN_CHECK_EN diverts vector memory ops with address_M[1:0]!=0 to a misalign flag.
module mem_access_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         regw_M,
    input  logic         memw_M,
    input  logic         regmem_M,
    input  logic         vec_M,
    input  logic [3:0]   regScr_M,
    input  logic [31:0]  ALUrslt_M,
    input  logic [31:0]  address_M,
    input  logic [127:0] regrsltV_M,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    output logic         mem_wren,
    input  logic [31:0]  mem_q,
    output logic         stall_M,
    output logic         regw_W,
    output logic         regmem_W,
    output logic         vec_W,
    output logic [3:0]   regScr_W,
    output logic [31:0]  ALUrslt_W,
    output logic [31:0]  memdata_W,
    output logic [127:0] regrsltV_W,
    output logic [127:0] vecdata_W,
    output logic         misalign_W
);

    typedef enum logic [1:0] {IDLE, VLOAD, VSTORE, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [1:0]     i_q, i_d;
    logic [95:0]    stage_q, stage_d;
    logic           regw_w_q, regw_w_d;
    logic           regmem_w_q, regmem_w_d;
    logic           vec_w_q, vec_w_d;
    logic [3:0]     regscr_w_q, regscr_w_d;
    logic [31:0]    alurslt_w_q, alurslt_w_d;
    logic [127:0]   regrsltv_w_q, regrsltv_w_d;
    logic [127:0]   vecdata_w_q, vecdata_w_d;
    logic           misalign_w_q, misalign_w_d;

    logic           stall_s, wren_s, misalign_s, vec_mem_s;
    logic [31:0]    addr_s, wdata_s;

    function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = v[31:0];
            2'd1:    w = v[63:32];
            2'd2:    w = v[95:64];
            2'd3:    w = v[127:96];
            default: w = v[31:0];
        endcase
        return w;
    endfunction

`ifdef ALIGN_CHECK_EN
    assign misalign_s = vec_M & (memw_M | regmem_M) & (address_M[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    assign vec_mem_s = vec_M & (memw_M | regmem_M) & ~misalign_s;

    // Vector sequencer: next state, word counter, RAM port and load staging.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        stage_d = stage_q;
        stall_s = 1'b0;
        wren_s  = 1'b0;
        addr_s  = address_M + {30'd0, i_q};
        wdata_s = ALUrslt_M;
        case (state_q)
            IDLE: begin
                addr_s = address_M;
                if (vec_mem_s) begin
                    stall_s = 1'b1;
                    i_d     = 2'd1;
                    if (memw_M) begin
                        wren_s  = 1'b1;
                        wdata_s = word_sel(regrsltV_M, 2'd0);
                        state_d = VSTORE;
                    end else begin
                        state_d = VLOAD;
                    end
                end else begin
                    // a misaligned vector store must not reach the RAM
                    wren_s = memw_M & ~vec_M;
                end
            end
            VLOAD: begin
                stall_s = 1'b1;
                case (i_q)
                    2'd1:    stage_d[31:0]  = mem_q;
                    2'd2:    stage_d[63:32] = mem_q;
                    2'd3:    stage_d[95:64] = mem_q;
                    default: stage_d        = stage_q;
                endcase
                if (i_q == 2'd3) begin
                    state_d = DRAIN;
                    i_d     = 2'd0;
                end else begin
                    i_d = i_q + 2'd1;
                end
            end
            VSTORE: begin
                wren_s  = 1'b1;
                wdata_s = word_sel(regrsltV_M, i_q);
                stall_s = (i_q != 2'd3);
                if (i_q == 2'd3) begin
                    state_d = IDLE;
                    i_d     = 2'd0;
                end else begin
                    i_d = i_q + 2'd1;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                i_d     = 2'd0;
            end
            default: begin
                state_d = IDLE;
                i_d     = 2'd0;
            end
        endcase
    end

    // M/W register next value: bubble while stalled, capture otherwise.
    always_comb begin
        regw_w_d     = regw_w_q;
        regmem_w_d   = regmem_w_q;
        vec_w_d      = vec_w_q;
        regscr_w_d   = regscr_w_q;
        alurslt_w_d  = alurslt_w_q;
        regrsltv_w_d = regrsltv_w_q;
        vecdata_w_d  = vecdata_w_q;
        misalign_w_d = misalign_w_q;
        if (stall_s) begin
            regw_w_d     = 1'b0;
            regmem_w_d   = 1'b0;
            vec_w_d      = 1'b0;
            misalign_w_d = 1'b0;
        end else begin
            regw_w_d     = regw_M & ~misalign_s;
            regmem_w_d   = regmem_M;
            vec_w_d      = vec_M;
            regscr_w_d   = regScr_M;
            alurslt_w_d  = ALUrslt_M;
            regrsltv_w_d = regrsltV_M;
            misalign_w_d = misalign_s;
            if (state_q == DRAIN) begin
                vecdata_w_d = {mem_q, stage_q};
            end else begin
                vecdata_w_d = vecdata_w_q;
            end
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            i_q          <= 2'd0;
            stage_q      <= 96'd0;
            regw_w_q     <= 1'b0;
            regmem_w_q   <= 1'b0;
            vec_w_q      <= 1'b0;
            regscr_w_q   <= 4'd0;
            alurslt_w_q  <= 32'd0;
            regrsltv_w_q <= 128'd0;
            vecdata_w_q  <= 128'd0;
            misalign_w_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            stage_q      <= stage_d;
            regw_w_q     <= regw_w_d;
            regmem_w_q   <= regmem_w_d;
            vec_w_q      <= vec_w_d;
            regscr_w_q   <= regscr_w_d;
            alurslt_w_q  <= alurslt_w_d;
            regrsltv_w_q <= regrsltv_w_d;
            vecdata_w_q  <= vecdata_w_d;
            misalign_w_q <= misalign_w_d;
        end
    end

    assign mem_addr   = addr_s;
    assign mem_wdata  = wdata_s;
    assign mem_wren   = wren_s & ~rst;
    assign stall_M    = stall_s & ~rst;
    assign regw_W     = regw_w_q;
    assign regmem_W   = regmem_w_q;
    assign vec_W      = vec_w_q;
    assign regScr_W   = regscr_w_q;
    assign ALUrslt_W  = alurslt_w_q;
    assign regrsltV_W = regrsltv_w_q;
    assign vecdata_W  = vecdata_w_q;
    assign misalign_W = misalign_w_q;
    assign memdata_W  = mem_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a synchronous-read RAM model.
// Honors ALIGN_CHECK_EN the same way as the design build.
module tb_mem_access_stage;

    logic         clk, rst;
    logic         regw_M, memw_M, regmem_M, vec_M;
    logic [3:0]   regScr_M;
    logic [31:0]  ALUrslt_M, address_M;
    logic [127:0] regrsltV_M;
    logic [31:0]  mem_addr, mem_wdata, mem_q;
    logic         mem_wren, stall_M;
    logic         regw_W, regmem_W, vec_W, misalign_W;
    logic [3:0]   regScr_W;
    logic [31:0]  ALUrslt_W, memdata_W;
    logic [127:0] regrsltV_W, vecdata_W;

    int checks   = 0;
    int failures = 0;

    logic [31:0]  ram    [0:255];
    logic [31:0]  shadow [0:255];
    logic [127:0] model_vec;

    typedef struct {
        logic         regw, regmem, vec, mis, chk_mem;
        logic [3:0]   rs;
        logic [31:0]  alu, memd;
        logic [127:0] rv, vd;
        int           stalls;
    } exp_t;
    exp_t sb[$];

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .regw_M(regw_M), .memw_M(memw_M), .regmem_M(regmem_M), .vec_M(vec_M),
        .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M), .address_M(address_M),
        .regrsltV_M(regrsltV_M),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q),
        .stall_M(stall_M),
        .regw_W(regw_W), .regmem_W(regmem_W), .vec_W(vec_W), .regScr_W(regScr_W),
        .ALUrslt_W(ALUrslt_W), .memdata_W(memdata_W), .regrsltV_W(regrsltV_W),
        .vecdata_W(vecdata_W), .misalign_W(misalign_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr[7:0]] <= mem_wdata;
        mem_q <= ram[mem_addr[7:0]];
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic misalign_model(input logic v, mw, rm, input logic [31:0] addr);
`ifdef ALIGN_CHECK_EN
        return v & (mw | rm) & (addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic rw, mw, rm, v, input logic [3:0] rs,
                         input logic [31:0] alu, addr, input logic [127:0] rv);
        regw_M = rw; memw_M = mw; regmem_M = rm; vec_M = v;
        regScr_M = rs; ALUrslt_M = alu; address_M = addr; regrsltV_M = rv;
    endtask

    task automatic check_w_zero(input string tag);
        check_val({tag, "_regw"}, 128'(regw_W), 128'(0));
        check_val({tag, "_regmem"}, 128'(regmem_W), 128'(0));
        check_val({tag, "_vec"}, 128'(vec_W), 128'(0));
        check_val({tag, "_scr"}, 128'(regScr_W), 128'(0));
        check_val({tag, "_alu"}, 128'(ALUrslt_W), 128'(0));
        check_val({tag, "_rv"}, regrsltV_W, 128'(0));
        check_val({tag, "_vd"}, vecdata_W, 128'(0));
        check_val({tag, "_mis"}, 128'(misalign_W), 128'(0));
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_op(input logic rw, mw, rm, v, input logic [3:0] rs,
                          input logic [31:0] alu, addr, input logic [127:0] rv);
        exp_t e;
        exp_t g;
        logic mis, vmem;
        logic [7:0] a;
        int stalls;
        a    = addr[7:0];
        mis  = misalign_model(v, mw, rm, addr);
        vmem = v & (mw | rm) & ~mis;
        e.regw = rw & ~mis; e.regmem = rm; e.vec = v; e.mis = mis;
        e.rs = rs; e.alu = alu; e.rv = rv;
        e.chk_mem = ~v & rm & ~mw;
        e.memd = shadow[a];
        e.stalls = vmem ? (mw ? 3 : 4) : 0;
        if (vmem & ~mw)
            model_vec = {shadow[a + 8'd3], shadow[a + 8'd2], shadow[a + 8'd1], shadow[a]};
        e.vd = model_vec;
        if (vmem & mw) begin
            for (int k = 0; k < 4; k++) shadow[a + 8'(k)] = rv[32*k +: 32];
        end else if (~v & mw) begin
            shadow[a] = alu;
        end
        sb.push_back(e);

        drive(rw, mw, rm, v, rs, alu, addr, rv);
        #1;
        stalls = 0;
        while (stall_M === 1'b1 && stalls < 8) begin
            if (stalls > 0) begin
                check_val("bubble_regw", 128'(regw_W), 128'(0));
                check_val("bubble_vec", 128'(vec_W), 128'(0));
            end
            check_val("stall_addr", 128'(mem_addr), 128'(addr + 32'(stalls)));
            check_val("stall_wren", 128'(mem_wren), 128'(mw));
            stalls++;
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);

        g = sb.pop_front();
        check_val("stalls", 128'(stalls), 128'(g.stalls));
        check_val("regw_W", 128'(regw_W), 128'(g.regw));
        check_val("regmem_W", 128'(regmem_W), 128'(g.regmem));
        check_val("vec_W", 128'(vec_W), 128'(g.vec));
        check_val("regScr_W", 128'(regScr_W), 128'(g.rs));
        check_val("ALUrslt_W", 128'(ALUrslt_W), 128'(g.alu));
        check_val("regrsltV_W", regrsltV_W, g.rv);
        check_val("vecdata_W", vecdata_W, g.vd);
        check_val("misalign_W", 128'(misalign_W), 128'(g.mis));
        if (g.chk_mem) check_val("memdata_W", 128'(memdata_W), 128'(g.memd));
        if (v & mw) begin
            for (int k = 0; k < 4; k++)
                check_val("ram_vec", 128'(ram[a + 8'(k)]), 128'(shadow[a + 8'(k)]));
        end else if (mw) begin
            check_val("ram_scalar", 128'(ram[a]), 128'(shadow[a]));
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            ram[k]    = 32'd0;
            shadow[k] = 32'd0;
        end
        model_vec = 128'd0;
        rst = 1'b1;
        // a vector store presented under reset must neither stall nor write
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'd0, 32'h40, 128'hFFFF);
        repeat (2) @(negedge clk);
        check_val("rst_stall", 128'(stall_M), 128'(0));
        check_val("rst_wren", 128'(mem_wren), 128'(0));
        check_w_zero("rst");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 128'd0);
        rst = 1'b0;

        run_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'hDEADBEEF, 32'h10, 128'd0);
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 32'd0, 32'h10, 128'd0);
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 32'h12345678, 32'h0, 128'd0);
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'd0, 32'h20,
               128'h44444444_33333333_22222222_11111111);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 32'd0, 32'h20, 128'd0);
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 32'h5, 32'h0,
               128'hCAFEF00D_01234567_89ABCDEF_0BADC0DE);
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'd0, 32'h21,
               128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h77, 32'h0, 128'd0);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 32'd0, 32'h21, 128'd0);
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'd0, 32'h30,
               128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 32'd0, 32'h30, 128'd0);

        // reset in the third cycle of a vector load
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 32'd0, 32'h20, 128'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_val("midload_stall", 128'(stall_M), 128'(1));
        check_val("midload_hold", vecdata_W, model_vec);
        rst = 1'b1;
        #1;
        check_val("midload_rst_stall", 128'(stall_M), 128'(0));
        check_val("midload_rst_wren", 128'(mem_wren), 128'(0));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 128'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_vec = 128'd0;
        check_w_zero("midload");

        run_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd11, 32'd0, 32'h20, 128'd0);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd12, 32'd0, 32'h20, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have these ports, one per entry (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- regw_M, memw_M, regmem_M  in  1 each  reg write, mem write, load select from the E/M register.
- vec_M  in  1  vector memory op.
- regScr_M  in  4  destination register.
- ALUrslt_M  in  32  scalar result / scalar store data.
- address_M  in  32  word address.
- regrsltV_M  in  128  vector result / vector store data.
- mem_addr  out  32  data RAM address.
- mem_wdata  out  32  data RAM write data.
- mem_wren  out  1  data RAM write enable.
- mem_q  in  32  RAM read data; synchronous, valid the cycle after the address.
- stall_M  out  1  holds the E/M register and the upstream pipeline.
- regw_W, regmem_W, vec_W  out  1 each  M/W control.
- regScr_W  out  4  M/W destination register.
- ALUrslt_W  out  32  M/W scalar result.
- memdata_W  out  32  scalar load data.
- regrsltV_W, vecdata_W  out  128 each  vector ALU result, vector load data.
- misalign_W  out  1  vector access misaligned.

Function
REQ-003 Scalar op (vec_M=0) SHALL complete in one cycle with stall_M=0: mem_addr=address_M; mem_wren=memw_M; mem_wdata=ALUrslt_M.
REQ-004 The M/W register SHALL capture regw, regmem, vec, regScr, ALUrslt and regrsltV at each edge where stall_M=0.
REQ-005 memdata_W SHALL be mem_q, combinational, valid while a scalar load occupies W.
REQ-006 If memw_M=1, the op SHALL be treated as a store regardless of regmem_M.
REQ-007 Vector ops SHALL be sequenced by the FSM IDLE, VLOAD, VSTORE, DRAIN using a 2-bit word counter i.
- Word i occupies bits [32i+31:32i].
- Word i is at address address_M+i.
REQ-008 Vector load SHALL run as follows:
- Cycle 0 (IDLE): issue word 0, go to VLOAD with i=1.
- VLOAD, cycles 1-3: issue word i, capture mem_q into word i-1 of the vecdata_W staging register.
- After i=3, go to DRAIN.
- DRAIN, cycle 4: capture word 3, set stall_M=0, return to IDLE.
- stall_M SHALL be 1 in cycles 0-3.
REQ-009 Vector store SHALL run as follows:
- Cycle 0 (IDLE) through cycle 3 (VSTORE): write word i with mem_wren=1.
- stall_M SHALL be 1 in cycles 0-2 and 0 in cycle 3, then the FSM returns to IDLE.
REQ-010 While stall_M=1, the W register SHALL load a bubble: regw_W=0, regmem_W=0, vec_W=0.
REQ-011 A vector op with memw_M=0 and regmem_M=0 SHALL be treated as a non-memory op and complete in one cycle.
REQ-012 vecdata_W SHALL hold its value until the next vector load completes.
REQ-013 mem_wren SHALL be 0 in DRAIN, in VLOAD, and in IDLE when no store is present.

Reset
REQ-014 rst SHALL return the FSM to IDLE with i=0.
REQ-015 Under rst, all *_W outputs SHALL be zero, including vecdata_W and misalign_W.
REQ-016 rst SHALL force stall_M=0 and mem_wren=0 combinationally in the same cycle.
REQ-017 rst during VLOAD or VSTORE SHALL abort the op; words already written stay in RAM, and no partial load is delivered.

Configuration
REQ-018 With ALIGN_CHECK_EN defined, a vector op with address_M[1:0]!=0 SHALL take this path:
- No RAM write, no stall.
- W receives regw_W=0 and misalign_W=1 for one cycle.
REQ-019 Without ALIGN_CHECK_EN, misalign_W SHALL be tied 0 and all vector addresses SHALL proceed.

Verification
REQ-020 Scalar load: RAM[0x10]=0xDEADBEEF; regmem_M=1, regw_M=1, regScr_M=3, address_M=0x10 -> next cycle regw_W=1, regScr_W=3, memdata_W=0xDEADBEEF, stall_M never 1.
REQ-021 Vector store: vec_M=1, memw_M=1, address_M=0x20, regrsltV_M=0x44444444_33333333_22222222_11111111 -> stall_M=1 for 3 cycles; RAM[0x20..0x23]=0x11111111, 0x22222222, 0x33333333, 0x44444444.
REQ-022 Vector load: vec_M=1, regmem_M=1, regw_M=1, address_M=0x20 -> stall_M=1 for 4 cycles, bubbles in W, then vecdata_W=0x44444444_33333333_22222222_11111111 and regw_W=1.
REQ-023 Reset mid-load: assert rst in cycle 2 of REQ-022 -> same cycle stall_M=0 and mem_wren=0; after the edge FSM=IDLE, all *_W outputs zero.
REQ-024 Alignment: with ALIGN_CHECK_EN, vector store at address_M=0x21 -> misalign_W=1, regw_W=0, RAM unchanged, stall_M=0; without the macro -> four writes to 0x21-0x24.
